ball_collision_resolver: RTL and testbench



---
 rtl/ball_collision_resolver.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_ball_collision_resolver.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ball_collision_resolver.sv
// ----------------------------------------------------------------------------
// ball_collision_resolver
//
// Sequential equal-mass elastic collision resolver for two billiard balls.
// A start pulse samples both centres and velocities. If the balls touch and
// are approaching, the impulse along the centre line is computed with a pair
// of restoring dividers and applied to both balls. Otherwise the velocities
// pass through unchanged.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start                      request pulse, sampled only while idle
//   x1, y1, x2, y2             unsigned centres of ball A and ball B
//   vax, vay, vbx, vby         signed velocities of ball A and ball B
//   vax_new .. vby_new         signed resolved velocities (registered)
//   hit                        last result was an approaching contact
//   valid                      one-cycle pulse when a new result is presented
//   busy                       request in flight (accept edge .. valid edge)
//
// Datapath lanes: index 0 is the x axis, index 1 is the y axis.
// ----------------------------------------------------------------------------
module ball_collision_resolver #(
    parameter int W      = 10,
    parameter int BALL_D = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [W-1:0]        x1,
    input  logic [W-1:0]        y1,
    input  logic [W-1:0]        x2,
    input  logic [W-1:0]        y2,
    input  logic signed [W-1:0] vax,
    input  logic signed [W-1:0] vay,
    input  logic signed [W-1:0] vbx,
    input  logic signed [W-1:0] vby,
    output logic signed [W-1:0] vax_new,
    output logic signed [W-1:0] vay_new,
    output logic signed [W-1:0] vbx_new,
    output logic signed [W-1:0] vby_new,
    output logic                hit,
    output logic                valid,
    output logic                busy
);

    localparam int CW = $clog2(W + 1);
    localparam logic [2*W+1:0]   D2_MAX = (2*W+2)'(BALL_D * BALL_D);
    localparam logic signed [W+2:0] SAT_HI = (W+3)'(2**(W-1) - 1);
    localparam logic signed [W+2:0] SAT_LO = -SAT_HI;

    typedef enum logic [2:0] {
        IDLE,
        DIFF,
        DOT,
        MUL,
        DIV,
        APPLY,
        PASS
    } state_t;

    state_t state_reg, state_next;

    // Input views as per-axis arrays
    logic [W-1:0]        pa_in [2];
    logic [W-1:0]        pb_in [2];
    logic signed [W-1:0] va_in [2];
    logic signed [W-1:0] vb_in [2];

    assign pa_in[0] = x1;
    assign pa_in[1] = y1;
    assign pb_in[0] = x2;
    assign pb_in[1] = y2;
    assign va_in[0] = vax;
    assign va_in[1] = vay;
    assign vb_in[0] = vbx;
    assign vb_in[1] = vby;

    // Registered request and intermediate values
    logic [W-1:0]          pa_reg   [2];
    logic [W-1:0]          pb_reg   [2];
    logic signed [W-1:0]   va_reg   [2];
    logic signed [W-1:0]   vb_reg   [2];
    logic signed [W:0]     d_reg    [2];
    logic signed [W:0]     dv_reg   [2];
    logic [2*W+1:0]        d2_reg;
    logic signed [2*W+2:0] p_reg;
    logic signed [3*W+3:0] n_reg    [2];
    logic                  neg_reg  [2];
    logic [2*W+2:0]        rem_reg  [2];
    logic [W:0]            low_reg  [2];
    logic [W:0]            q_reg    [2];
    logic [CW-1:0]         cnt_reg;
    logic                  mul_phase_reg;

    logic signed [W-1:0]   va_new_reg [2];
    logic signed [W-1:0]   vb_new_reg [2];
    logic                  hit_reg;
    logic                  valid_reg;

    // Combinational per-lane arithmetic
    logic signed [2*W+1:0] sq       [2];
    logic signed [2*W+2:0] pp       [2];
    logic signed [3*W+3:0] n_c      [2];
    logic [3*W+3:0]        mag_c    [2];
    logic [3*W+3:0]        dividend [2];
    logic [2*W+3:0]        trial    [2];
    logic                  ge       [2];
    logic [2*W+2:0]        sub      [2];
    logic [2*W+2:0]        rem_n    [2];
    logic signed [W+1:0]   j        [2];
    logic signed [W+2:0]   sum_a    [2];
    logic signed [W+2:0]   sum_b    [2];

    logic [2*W+1:0]        d2_c;
    logic signed [2*W+2:0] p_c;
    logic                  contact_c;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            // DOT: squared distance and approach-rate terms
            assign sq[gi] = (2*W+2)'(d_reg[gi]) * (2*W+2)'(d_reg[gi]);
            assign pp[gi] = (2*W+3)'(dv_reg[gi]) * (2*W+3)'(d_reg[gi]);

            // MUL: numerator, its magnitude, and half-divisor rounding bias
            assign n_c[gi]      = (3*W+4)'(p_reg) * (3*W+4)'(d_reg[gi]);
            assign mag_c[gi]    = n_reg[gi][3*W+3] ? -n_reg[gi] : n_reg[gi];
            assign dividend[gi] = mag_c[gi] + (3*W+4)'(d2_reg >> 1);

            // DIV: one restoring step. When the trial fits, the difference
            // is below d2, so the low bits of the subtraction are exact.
            assign trial[gi] = {rem_reg[gi], low_reg[gi][W]};
            assign ge[gi]    = (trial[gi] >= (2*W+4)'(d2_reg));
            assign sub[gi]   = trial[gi][2*W+2:0] - (2*W+3)'(d2_reg);
            assign rem_n[gi] = ge[gi] ? sub[gi] : trial[gi][2*W+2:0];

            // APPLY: signed impulse and widened updates before saturation
            assign j[gi]     = neg_reg[gi] ? -$signed({1'b0, q_reg[gi]})
                                           :  $signed({1'b0, q_reg[gi]});
            assign sum_a[gi] = (W+3)'(va_reg[gi]) - (W+3)'(j[gi]);
            assign sum_b[gi] = (W+3)'(vb_reg[gi]) + (W+3)'(j[gi]);
        end
    endgenerate

    assign d2_c      = $unsigned(sq[0]) + $unsigned(sq[1]);
    assign p_c       = pp[0] + pp[1];
    assign contact_c = (d2_c <= D2_MAX) && (d2_c != '0) &&
                       !p_c[2*W+2] && (p_c != '0);

    function automatic logic signed [W-1:0] sat(input logic signed [W+2:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[W-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[W-1:0];
        end
        return v[W-1:0];
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = DIFF;
            DIFF:    state_next = DOT;
            DOT:     state_next = contact_c ? MUL : PASS;
            // Two cycles: product register, then magnitude/bias/divider load
            MUL:     if (mul_phase_reg) state_next = DIV;
            DIV:     if (cnt_reg == CW'(W)) state_next = APPLY;
            APPLY:   state_next = IDLE;
            PASS:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                pa_reg[i]     <= '0;
                pb_reg[i]     <= '0;
                va_reg[i]     <= '0;
                vb_reg[i]     <= '0;
                d_reg[i]      <= '0;
                dv_reg[i]     <= '0;
                n_reg[i]      <= '0;
                neg_reg[i]    <= 1'b0;
                rem_reg[i]    <= '0;
                low_reg[i]    <= '0;
                q_reg[i]      <= '0;
                va_new_reg[i] <= '0;
                vb_new_reg[i] <= '0;
            end
            d2_reg        <= '0;
            p_reg         <= '0;
            cnt_reg       <= '0;
            mul_phase_reg <= 1'b0;
            hit_reg       <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 2; i++) begin
                            pa_reg[i] <= pa_in[i];
                            pb_reg[i] <= pb_in[i];
                            va_reg[i] <= va_in[i];
                            vb_reg[i] <= vb_in[i];
                        end
                    end
                end
                DIFF: begin
                    for (int i = 0; i < 2; i++) begin
                        d_reg[i]  <= $signed({1'b0, pb_reg[i]}) - $signed({1'b0, pa_reg[i]});
                        dv_reg[i] <= (W+1)'(va_reg[i]) - (W+1)'(vb_reg[i]);
                    end
                end
                DOT: begin
                    d2_reg <= d2_c;
                    p_reg  <= p_c;
                end
                MUL: begin
                    if (!mul_phase_reg) begin
                        for (int i = 0; i < 2; i++) begin
                            n_reg[i] <= n_c[i];
                        end
                        mul_phase_reg <= 1'b1;
                    end else begin
                        // The quotient fits in W+1 bits, so the dividend bits
                        // above the first W+1 shift-ins are already below d2.
                        for (int i = 0; i < 2; i++) begin
                            neg_reg[i] <= n_reg[i][3*W+3];
                            rem_reg[i] <= dividend[i][3*W+3:W+1];
                            low_reg[i] <= dividend[i][W:0];
                            q_reg[i]   <= '0;
                        end
                        cnt_reg       <= '0;
                        mul_phase_reg <= 1'b0;
                    end
                end
                DIV: begin
                    for (int i = 0; i < 2; i++) begin
                        rem_reg[i] <= rem_n[i];
                        low_reg[i] <= {low_reg[i][W-1:0], 1'b0};
                        q_reg[i]   <= {q_reg[i][W-1:0], ge[i]};
                    end
                    cnt_reg <= cnt_reg + CW'(1);
                end
                APPLY: begin
                    for (int i = 0; i < 2; i++) begin
                        va_new_reg[i] <= sat(sum_a[i]);
                        vb_new_reg[i] <= sat(sum_b[i]);
                    end
                    hit_reg   <= 1'b1;
                    valid_reg <= 1'b1;
                end
                PASS: begin
                    for (int i = 0; i < 2; i++) begin
                        va_new_reg[i] <= va_reg[i];
                        vb_new_reg[i] <= vb_reg[i];
                    end
                    hit_reg   <= 1'b0;
                    valid_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign vax_new = va_new_reg[0];
    assign vay_new = va_new_reg[1];
    assign vbx_new = vb_new_reg[0];
    assign vby_new = vb_new_reg[1];
    assign hit     = hit_reg;
    assign valid   = valid_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_ball_collision_resolver.sv
// ----------------------------------------------------------------------------
// tb_ball_collision_resolver
//
// Self-checking bench for ball_collision_resolver (W=10, BALL_D=24).
// A table of directed vectors with hand-computed results is applied one
// request at a time; each request checks busy, latency, the four resolved
// velocities, hit and the single-cycle valid pulse. Hand-written sequences
// cover start-while-busy and reset in the middle of the divide.
// ----------------------------------------------------------------------------
module tb_ball_collision_resolver;

    localparam int W = 10;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [W-1:0]        x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic signed [W-1:0] vax = '0, vay = '0, vbx = '0, vby = '0;
    logic signed [W-1:0] vax_new, vay_new, vbx_new, vby_new;
    logic                hit, valid, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ball_collision_resolver #(.W(W), .BALL_D(24)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x1      (x1),
        .y1      (y1),
        .x2      (x2),
        .y2      (y2),
        .vax     (vax),
        .vay     (vay),
        .vbx     (vbx),
        .vby     (vby),
        .vax_new (vax_new),
        .vay_new (vay_new),
        .vbx_new (vbx_new),
        .vby_new (vby_new),
        .hit     (hit),
        .valid   (valid),
        .busy    (busy)
    );

    typedef struct {
        string name;
        int    x1, y1, x2, y2;
        int    vax, vay, vbx, vby;
        int    eax, eay, ebx, eby;
        int    ehit;
        int    elat;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        x1  = 10'(v.x1);
        y1  = 10'(v.y1);
        x2  = 10'(v.x2);
        y2  = 10'(v.y2);
        vax = 10'(v.vax);
        vay = 10'(v.vay);
        vbx = 10'(v.vbx);
        vby = 10'(v.vby);
    endtask

    task automatic scramble();
        x1  = 10'($urandom);
        y1  = 10'($urandom);
        x2  = 10'($urandom);
        y2  = 10'($urandom);
        vax = 10'($urandom);
        vay = 10'($urandom);
        vbx = 10'($urandom);
        vby = 10'($urandom);
    endtask

    task automatic check_outs(input vec_t v, input string tag);
        check({v.name, tag, " vax_new"}, int'(vax_new), v.eax);
        check({v.name, tag, " vay_new"}, int'(vay_new), v.eay);
        check({v.name, tag, " vbx_new"}, int'(vbx_new), v.ebx);
        check({v.name, tag, " vby_new"}, int'(vby_new), v.eby);
        check({v.name, tag, " hit"},     int'(hit),     v.ehit);
    endtask

    task automatic do_vec(input vec_t v);
        int lat;
        bit got;
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(posedge clk);             // edge 0
        #1;
        check({v.name, " busy_rise"}, int'(busy), 1);
        start = 1'b0;
        scramble();
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                got = 1'b1;
                lat = c;
            end
        end
        check({v.name, " latency"}, lat, v.elat);
        check({v.name, " busy_fall"}, int'(busy), 0);
        check_outs(v, "");
        $display("vec %-12s lat=%0d A'=(%0d,%0d) B'=(%0d,%0d) hit=%0d",
                 v.name, lat, vax_new, vay_new, vbx_new, vby_new, hit);
        @(posedge clk);
        #1;
        check({v.name, " valid_pulse"}, int'(valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          name           x1   y1   x2   y2  vax  vay  vbx  vby  eax  eay  ebx  eby hit lat
        tbl[0]  = '{"head_on",    100, 100, 124, 100,   5,   0,   0,   0,   0,   0,   5,   0, 1, 16};
        tbl[1]  = '{"diag45",     100, 100, 112, 112,   4,   4,   0,   0,   0,   0,   4,   4, 1, 16};
        tbl[2]  = '{"glancing",   100, 100, 124, 100,   3,   4,   0,   0,   0,   4,   3,   0, 1, 16};
        tbl[3]  = '{"reverse",    124, 100, 100, 100,   0,   0,   5,   0,   5,   0,   0,   0, 1, 16};
        tbl[4]  = '{"saturate",   100, 100, 124, 100, 511,   0,-512,   0,-511,   0, 511,   0, 1, 16};
        tbl[5]  = '{"separating", 100, 100, 124, 100,  -5,   0,   0,   0,  -5,   0,   0,   0, 0,  3};
        tbl[6]  = '{"distant",    100, 100, 130, 100,   5,   0,   0,   0,   5,   0,   0,   0, 0,  3};
        tbl[7]  = '{"concentric", 200, 200, 200, 200,   3,  -2,   1,   1,   3,  -2,   1,   1, 0,  3};
        tbl[8]  = '{"just_out",   100, 100, 124, 101,   5,   0,   0,   0,   5,   0,   0,   0, 0,  3};
        tbl[9]  = '{"vertical",   300, 300, 300, 276,   0,  -2,   0,   3,   0,   3,   0,  -2, 1, 16};
        tbl[10] = '{"rt345",      100, 100, 112, 116,   5,   0,   0,   0,   3,  -2,   2,   2, 1, 16};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset vax_new", int'(vax_new), 0);
        check("reset vay_new", int'(vay_new), 0);
        check("reset vbx_new", int'(vbx_new), 0);
        check("reset vby_new", int'(vby_new), 0);
        check("reset hit",     int'(hit),     0);
        check("reset valid",   int'(valid),   0);
        check("reset busy",    int'(busy),    0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_vec(tbl[i]);
        end

        // start while busy: extra starts at edges 5 and 10 are ignored
        begin
            int nval;
            int vedge;
            nval  = 0;
            vedge = 0;
            @(negedge clk);
            drive(tbl[2]);
            start = 1'b1;
            @(posedge clk);         // edge 0
            for (int c = 1; c <= 30; c++) begin
                @(negedge clk);
                start = (c == 5 || c == 10);
                drive(tbl[0]);
                @(posedge clk);
                #1;
                if (valid) begin
                    nval++;
                    if (vedge == 0) vedge = c;
                end
            end
            start = 1'b0;
            check("busy_start valid_count", nval, 1);
            check("busy_start valid_edge", vedge, 16);
            check_outs(tbl[2], " busy_start");
            $display("seq start_while_busy valids=%0d edge=%0d A'=(%0d,%0d) B'=(%0d,%0d)",
                     nval, vedge, vax_new, vay_new, vbx_new, vby_new);
        end

        // reset in the middle of the divide
        begin
            int nval;
            nval = 0;
            @(negedge clk);
            drive(tbl[1]);
            start = 1'b1;
            @(posedge clk);         // edge 0
            #1;
            start = 1'b0;
            repeat (8) @(posedge clk);   // edge 8
            #1;
            rst = 1'b1;
            #1;
            check("mid_rst vax_new", int'(vax_new), 0);
            check("mid_rst vay_new", int'(vay_new), 0);
            check("mid_rst vbx_new", int'(vbx_new), 0);
            check("mid_rst vby_new", int'(vby_new), 0);
            check("mid_rst hit",     int'(hit),     0);
            check("mid_rst busy",    int'(busy),    0);
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 25; c++) begin
                @(posedge clk);
                #1;
                if (valid) nval++;
            end
            check("mid_rst no_valid", nval, 0);
            $display("seq reset_mid_div valids_after=%0d busy=%0d", nval, busy);
            do_vec(tbl[10]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
